// File: rtl/dump_pkg.sv
// Shared types for the post-halt dump engine: FSM states, stream word kinds, width helpers.
package dump_pkg;

   typedef enum logic [2:0] {
      IDLE, MEM_RD, MEM_CAP, MEM_OUT, REG_RD, REG_CAP, REG_OUT, CNT_OUT
   } dump_state_e;

   localparam logic [1:0] KIND_MEM = 2'd0;
   localparam logic [1:0] KIND_REG = 2'd1;
   localparam logic [1:0] KIND_CNT = 2'd2;

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/halt_dump_unit.sv
// Post-halt dump engine: streams data memory, register file and the run cycle count,
// and checks one register against an expected value.
//
//   state   | meaning
//   IDLE    | counting cycles, waiting for halt edge or dump_req
//   MEM_RD  | memory address i presented
//   MEM_CAP | memory word captured into the output register
//   MEM_OUT | memory word offered until accepted
//   REG_RD  | register index j presented
//   REG_CAP | register word captured, CHECK_REG compared
//   REG_OUT | register word offered until accepted
//   CNT_OUT | cycle count offered with out_last
module halt_dump_unit
   import dump_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int MEM_DEPTH = 16,
   parameter int REG_CNT   = 10,
   parameter int CNT_W     = 32,
   parameter int CHECK_REG = 7,
   localparam int MA_W     = addr_w(MEM_DEPTH),
   localparam int RA_W     = addr_w(REG_CNT),
   localparam int OUT_W    = max_w(DATA_W, CNT_W)
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              do_halt,
   input  logic              dump_req,
   output logic [MA_W-1:0]   mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [RA_W-1:0]   reg_raddr,
   input  logic [DATA_W-1:0] reg_rdata,
   input  logic [DATA_W-1:0] expect_val,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic [1:0]        out_kind,
   output logic [7:0]        out_index,
   output logic              out_last,
   output logic              busy,
   output logic              check_pass,
   output logic              check_fail
);

   localparam logic [MA_W-1:0] MEM_LAST = MA_W'(MEM_DEPTH - 1);
   localparam logic [RA_W-1:0] REG_LAST = RA_W'(REG_CNT - 1);
   localparam logic [RA_W-1:0] REG_CHK  = RA_W'(CHECK_REG);

   dump_state_e      state_q, state_d;
   logic [MA_W-1:0]  mem_idx_q, mem_idx_d;
   logic [RA_W-1:0]  reg_idx_q, reg_idx_d;
   logic             halt_q;
   logic             valid_q, valid_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic [1:0]       kind_q, kind_d;
   logic [7:0]       index_q, index_d;
   logic             last_q, last_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic [CNT_W-1:0] cycles;
   logic             trigger, xfer, cnt_en, cnt_clr;

   assign trigger = (halt_q & ~do_halt) | dump_req;
   assign xfer    = valid_q & out_ready;
   // The count freezes on the trigger cycle and restarts from zero once the CNT word is taken.
   assign cnt_en  = (state_q == IDLE) & ~trigger;
   assign cnt_clr = (state_q == CNT_OUT) & xfer;

   sat_counter #(.CNT_W(CNT_W)) u_cycles (
      .CLK   (CLK),
      .rst   (rst),
      .en    (cnt_en),
      .clr   (cnt_clr),
      .cnt_o (cycles)
   );

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         mem_idx_q <= '0;
         reg_idx_q <= '0;
         halt_q    <= 1'b0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         kind_q    <= 2'd0;
         index_q   <= 8'd0;
         last_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mem_idx_q <= mem_idx_d;
         reg_idx_q <= reg_idx_d;
         halt_q    <= do_halt;
         valid_q   <= valid_d;
         data_q    <= data_d;
         kind_q    <= kind_d;
         index_q   <= index_d;
         last_q    <= last_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mem_idx_d = mem_idx_q;
      reg_idx_d = reg_idx_q;
      valid_d   = valid_q;
      data_d    = data_q;
      kind_d    = kind_q;
      index_d   = index_q;
      last_d    = last_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      case (state_q)
         IDLE: begin
            if (trigger) begin
               mem_idx_d = '0;
               reg_idx_d = '0;
               pass_d    = 1'b0;
               fail_d    = 1'b0;
               state_d   = MEM_RD;
            end
         end
         MEM_RD: state_d = MEM_CAP;
         MEM_CAP: begin
            data_d  = OUT_W'(mem_rdata);
            kind_d  = KIND_MEM;
            index_d = 8'(mem_idx_q);
            last_d  = 1'b0;
            valid_d = 1'b1;
            state_d = MEM_OUT;
         end
         MEM_OUT: begin
            if (xfer) begin
               valid_d = 1'b0;
               if (mem_idx_q == MEM_LAST) begin
                  reg_idx_d = '0;
                  state_d   = REG_RD;
               end else begin
                  mem_idx_d = mem_idx_q + MA_W'(1);
                  state_d   = MEM_RD;
               end
            end
         end
         REG_RD: state_d = REG_CAP;
         REG_CAP: begin
            data_d  = OUT_W'(reg_rdata);
            kind_d  = KIND_REG;
            index_d = 8'(reg_idx_q);
            last_d  = 1'b0;
            valid_d = 1'b1;
            if (reg_idx_q == REG_CHK) begin
               pass_d = (reg_rdata == expect_val);
               fail_d = (reg_rdata != expect_val);
            end
            state_d = REG_OUT;
         end
         REG_OUT: begin
            if (xfer) begin
               if (reg_idx_q == REG_LAST) begin
                  data_d  = OUT_W'(cycles);
                  kind_d  = KIND_CNT;
                  index_d = 8'd0;
                  last_d  = 1'b1;
                  state_d = CNT_OUT;
               end else begin
                  valid_d   = 1'b0;
                  reg_idx_d = reg_idx_q + RA_W'(1);
                  state_d   = REG_RD;
               end
            end
         end
         CNT_OUT: begin
            if (xfer) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_raddr  = mem_idx_q;
   assign reg_raddr  = reg_idx_q;
   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign out_kind   = kind_q;
   assign out_index  = index_q;
   assign out_last   = last_q;
   assign busy       = (state_q != IDLE);
   assign check_pass = pass_q;
   assign check_fail = fail_q;

endmodule

// File: tb/tb_halt_dump_unit.sv
// Directed bench: default unit (a), CNT_W=4 unit (c) and 32/16-deep unit (b) share clock, reset and out_ready.
module tb_halt_dump_unit;

   typedef logic [42:0] word_t;

   logic CLK, rst, out_ready, bad_reg;
   logic [15:0] expect_val;
   int checks, errors, cyc;
   int ncyc_a, ncyc_b, ncyc_c;

   logic do_halt_a, dump_req_a, out_valid_a, out_last_a, busy_a, check_pass_a, check_fail_a;
   logic [3:0] mem_raddr_a, reg_raddr_a;
   logic [15:0] mem_rdata_a, reg_rdata_a;
   logic [31:0] out_data_a;
   logic [1:0] out_kind_a;
   logic [7:0] out_index_a;

   logic do_halt_c, dump_req_c, out_valid_c, out_last_c, busy_c, check_pass_c, check_fail_c;
   logic [3:0] mem_raddr_c, reg_raddr_c;
   logic [15:0] mem_rdata_c, reg_rdata_c;
   logic [15:0] out_data_c;
   logic [1:0] out_kind_c;
   logic [7:0] out_index_c;

   logic do_halt_b, dump_req_b, out_valid_b, out_last_b, busy_b, check_pass_b, check_fail_b;
   logic [4:0] mem_raddr_b;
   logic [3:0] reg_raddr_b;
   logic [15:0] mem_rdata_b, reg_rdata_b;
   logic [31:0] out_data_b;
   logic [1:0] out_kind_b;
   logic [7:0] out_index_b;

   word_t word_a, word_b, word_c;
   word_t q_a[$], q_b[$], q_c[$];

   assign word_a = {out_data_a, out_kind_a, out_index_a, out_last_a};
   assign word_b = {out_data_b, out_kind_b, out_index_b, out_last_b};
   assign word_c = {16'd0, out_data_c, out_kind_c, out_index_c, out_last_c};

   halt_dump_unit u_dut_a (
      .CLK(CLK), .rst(rst), .do_halt(do_halt_a), .dump_req(dump_req_a),
      .mem_raddr(mem_raddr_a), .mem_rdata(mem_rdata_a), .reg_raddr(reg_raddr_a), .reg_rdata(reg_rdata_a),
      .expect_val(expect_val), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
      .out_kind(out_kind_a), .out_index(out_index_a), .out_last(out_last_a), .busy(busy_a),
      .check_pass(check_pass_a), .check_fail(check_fail_a));

   halt_dump_unit #(.CNT_W(4)) u_dut_c (
      .CLK(CLK), .rst(rst), .do_halt(do_halt_c), .dump_req(dump_req_c),
      .mem_raddr(mem_raddr_c), .mem_rdata(mem_rdata_c), .reg_raddr(reg_raddr_c), .reg_rdata(reg_rdata_c),
      .expect_val(expect_val), .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
      .out_kind(out_kind_c), .out_index(out_index_c), .out_last(out_last_c), .busy(busy_c),
      .check_pass(check_pass_c), .check_fail(check_fail_c));

   halt_dump_unit #(.MEM_DEPTH(32), .REG_CNT(16)) u_dut_b (
      .CLK(CLK), .rst(rst), .do_halt(do_halt_b), .dump_req(dump_req_b),
      .mem_raddr(mem_raddr_b), .mem_rdata(mem_rdata_b), .reg_raddr(reg_raddr_b), .reg_rdata(reg_rdata_b),
      .expect_val(expect_val), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
      .out_kind(out_kind_b), .out_index(out_index_b), .out_last(out_last_b), .busy(busy_b),
      .check_pass(check_pass_b), .check_fail(check_fail_b));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Synchronous memory / register-file models: mem[k]=3k, reg[k]=k, reg[7]=6 when bad_reg.
   always @(posedge CLK) begin
      mem_rdata_a <= 16'(mem_raddr_a) * 16'd3;
      mem_rdata_c <= 16'(mem_raddr_c) * 16'd3;
      mem_rdata_b <= 16'(mem_raddr_b) * 16'd3;
      reg_rdata_a <= (reg_raddr_a == 4'd7 && bad_reg) ? 16'd6 : 16'(reg_raddr_a);
      reg_rdata_c <= (reg_raddr_c == 4'd7 && bad_reg) ? 16'd6 : 16'(reg_raddr_c);
      reg_rdata_b <= (reg_raddr_b == 4'd7 && bad_reg) ? 16'd6 : 16'(reg_raddr_b);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
      cyc += n;
   endtask

   // Takes the trigger edge, then runs until every unit is idle, collecting accepted words.
   // mode 1: backpressure; mode 2: late triggers mid-dump; mode 3: reset at word 18 of unit a.
   task automatic run(input int mode);
      int n, w, stall;
      logic pv, hold;
      word_t held;
      n = 0; w = 0; stall = 0; pv = 1'b0; hold = 1'b0; held = '0;
      ncyc_a = 0; ncyc_b = 0; ncyc_c = 0;
      tick(1);
      dump_req_a = 1'b0;
      dump_req_b = 1'b0;
      dump_req_c = 1'b0;
      chk("trig_busy", 64'(busy_a | busy_b | busy_c), 64'd1);
      chk("trig_flags_clear", 64'({check_pass_a, check_fail_a}), 64'd0);
      while ((busy_a || busy_b || busy_c) && n < 400) begin
         if (hold) chk("stall_hold", 64'({out_valid_a, word_a}), 64'({1'b1, held}));
         if (busy_a) ncyc_a++;
         if (busy_b) ncyc_b++;
         if (busy_c) ncyc_c++;
         if (mode == 1) begin
            if (out_valid_a && !pv) begin
               w++;
               if (w % 4 == 0) stall = 5;
            end
            pv = out_valid_a;
            if (stall > 0) begin
               out_ready = 1'b0;
               stall--;
            end else begin
               out_ready = 1'b1;
            end
         end
         if (mode == 2) begin
            if (n == 18) do_halt_a = 1'b1;
            if (n == 19) begin do_halt_a = 1'b0; dump_req_a = 1'b1; end
            if (n == 20) dump_req_a = 1'b0;
         end
         if (mode == 3 && q_a.size() == 17 && out_valid_a) begin
            rst = 1'b0;
            #1;
            chk("abort_a_outputs", 64'({out_valid_a, busy_a, out_data_a, out_kind_a, out_index_a, out_last_a,
                                        check_pass_a, check_fail_a, mem_raddr_a, reg_raddr_a}), 64'd0);
            chk("abort_b_outputs", 64'({out_valid_b, busy_b, out_data_b, out_kind_b, out_index_b, out_last_b,
                                        mem_raddr_b, reg_raddr_b}), 64'd0);
            break;
         end
         hold = out_valid_a && !out_ready;
         held = word_a;
         if (out_valid_a && out_ready) q_a.push_back(word_a);
         if (out_valid_b && out_ready) q_b.push_back(word_b);
         if (out_valid_c && out_ready) q_c.push_back(word_c);
         tick(1);
         n++;
      end
      out_ready = 1'b1;
      chk("run_bounded", 64'(n < 400), 64'd1);
   endtask

   task automatic check_q(input string tag, input word_t q[$], input int md, input int rc,
                          input logic [31:0] cnt, input logic [15:0] r7);
      logic [31:0] d;
      logic [1:0] k;
      logic [7:0] idx;
      logic l;
      word_t got;
      chk({tag, "_len"}, 64'(q.size()), 64'(md + rc + 1));
      for (int w = 0; w < md + rc + 1; w++) begin
         l = 1'b0;
         if (w < md) begin
            d = 32'(w * 3); k = 2'd0; idx = 8'(w);
         end else if (w < md + rc) begin
            idx = 8'(w - md); k = 2'd1;
            d = (idx == 8'd7) ? 32'(r7) : 32'(idx);
         end else begin
            d = cnt; k = 2'd2; idx = 8'd0; l = 1'b1;
         end
         got = (w < q.size()) ? q[w] : '0;
         chk($sformatf("%s_w%0d", tag, w), 64'(got), 64'({d, k, idx, l}));
      end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      rst = 1'b0; out_ready = 1'b1; bad_reg = 1'b0; expect_val = 16'd7;
      do_halt_a = 1'b1; do_halt_b = 1'b1; do_halt_c = 1'b1;
      dump_req_a = 1'b0; dump_req_b = 1'b0; dump_req_c = 1'b0;
      #3;
      chk("reset_outputs", 64'({out_valid_a, busy_a, out_data_a, out_kind_a, out_index_a, out_last_a,
                                check_pass_a, check_fail_a, mem_raddr_a, reg_raddr_a}), 64'd0);
      @(posedge CLK);
      #1;
      rst = 1'b1;
      cyc = 0;

      // Unit c halts at cycle 40; its 4-bit counter has long saturated.
      tick(40);
      do_halt_c = 1'b0;
      run(0);
      chk("c_busy_cycles", 64'(ncyc_c), 64'd79);
      check_q("c_stream", q_c, 16, 10, 32'd15, 16'd7);
      chk("c_flags", 64'({check_pass_c, check_fail_c}), 64'b10);

      // Units a and b halt at cycle 500.
      tick(500 - cyc);
      do_halt_a = 1'b0;
      do_halt_b = 1'b0;
      run(0);
      chk("a_busy_cycles", 64'(ncyc_a), 64'd79);
      chk("b_busy_cycles", 64'(ncyc_b), 64'd145);
      check_q("a_stream", q_a, 16, 10, 32'd500, 16'd7);
      check_q("b_stream", q_b, 32, 16, 32'd500, 16'd7);
      chk("a_flags_pass", 64'({check_pass_a, check_fail_a}), 64'b10);

      // Wrong reg[7]. Unit a idled for the 66 cycles b was still dumping, plus 3 here: CNT = 69.
      bad_reg = 1'b1;
      do_halt_a = 1'b1;
      tick(3);
      q_a.delete();
      do_halt_a = 1'b0;
      run(0);
      chk("a2_busy_cycles", 64'(ncyc_a), 64'd79);
      check_q("a2_stream", q_a, 16, 10, 32'd69, 16'd6);
      chk("a2_flags_fail", 64'({check_pass_a, check_fail_a}), 64'b01);

      // Backpressure: 5 stalled cycles on words 4,8,..,24 adds 30 cycles.
      bad_reg = 1'b0;
      do_halt_a = 1'b1;
      tick(3);
      q_a.delete();
      do_halt_a = 1'b0;
      run(1);
      chk("a3_busy_cycles", 64'(ncyc_a), 64'd109);
      check_q("a3_stream", q_a, 16, 10, 32'd3, 16'd7);
      chk("a3_flags_pass", 64'({check_pass_a, check_fail_a}), 64'b10);

      // Halt edge and dump_req while busy are dropped.
      do_halt_a = 1'b1;
      tick(3);
      q_a.delete();
      do_halt_a = 1'b0;
      run(2);
      chk("a4_busy_cycles", 64'(ncyc_a), 64'd79);
      check_q("a4_stream", q_a, 16, 10, 32'd3, 16'd7);
      tick(4);
      chk("a4_no_requeue", 64'(busy_a), 64'd0);

      // dump_req from IDLE: counter restarted at the end of the last dump.
      dump_req_a = 1'b1;
      q_a.delete();
      run(0);
      check_q("a5_stream", q_a, 16, 10, 32'd4, 16'd7);

      // Reset during word 18 (REG index 1) of a; b is at the same point of its MEM phase.
      tick(2);
      q_a.delete();
      q_b.delete();
      dump_req_a = 1'b1;
      dump_req_b = 1'b1;
      run(3);
      tick(1);
      rst = 1'b1;
      tick(20);
      chk("abort_a_words", 64'(q_a.size()), 64'd17);
      chk("abort_b_words", 64'(q_b.size()), 64'd17);
      chk("abort_idle", 64'({busy_a, busy_b, out_valid_a, out_valid_b}), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
